// File: rtl/ar_uid_allocator.sv
// UID pool for the AR ordering unit: grants the lowest free UID,
// records the original AXI ID on issue, and releases UIDs on R last.
module ar_uid_allocator #(
  parameter int ID_WIDTH  = 4,
  parameter int UID_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  input  logic [ID_WIDTH-1:0]    alloc_in_id,
  input  logic                   alloc_commit,
  output logic                   alloc_gnt,
  output logic [UID_WIDTH-1:0]   alloc_uid,
  input  logic                   free_valid,
  input  logic [UID_WIDTH-1:0]   free_uid,
  input  logic [UID_WIDTH-1:0]   lookup_uid,
  output logic [ID_WIDTH-1:0]    lookup_orig_id,
  output logic [2**UID_WIDTH-1:0] busy_vec,
  output logic [UID_WIDTH:0]     outstanding,
  output logic                   pool_full,
  output logic                   err_free_idle
);

  localparam int NUM_UIDS = 2**UID_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [UID_WIDTH-1:0]  uid_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ID_WIDTH-1:0]   map_table [NUM_UIDS];
  logic [UID_WIDTH-1:0]  pick_uid;
  logic                  any_free;
  logic                  latch;
  logic                  commit;
  logic                  free_ok;
  logic                  free_bad;
  logic [NUM_UIDS-1:0]   set_mask;
  logic [NUM_UIDS-1:0]   clr_mask;

  // Lowest-index free UID, from the registered bitmap only.
  always_comb begin
    pick_uid = '0;
    any_free = 1'b0;
    for (int i = NUM_UIDS - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        pick_uid = UID_WIDTH'(i);
        any_free = 1'b1;
      end
    end
  end

  assign latch    = (state == IDLE) && alloc_req && any_free;
  assign commit   = (state == GRANT) && alloc_commit;
  assign free_ok  = free_valid && busy_vec[free_uid];
  assign free_bad = free_valid && !busy_vec[free_uid];
  assign set_mask = commit  ? (NUM_UIDS'(1) << uid_q)    : '0;
  assign clr_mask = free_ok ? (NUM_UIDS'(1) << free_uid) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (latch) state_nxt = GRANT;
      end
      GRANT: begin
        if (alloc_commit || !alloc_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alloc_gnt = (state == GRANT);
    alloc_uid = uid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uid_q         <= '0;
      id_q          <= '0;
      busy_vec      <= '0;
      outstanding   <= '0;
      err_free_idle <= 1'b0;
      for (int i = 0; i < NUM_UIDS; i++) begin
        map_table[i] <= '0;
      end
    end else begin
      if (latch) begin
        uid_q <= pick_uid;
        id_q  <= alloc_in_id;
      end
      if (commit) map_table[uid_q] <= id_q;
      busy_vec <= (busy_vec & ~clr_mask) | set_mask;
      if (commit && !free_ok) begin
        outstanding <= outstanding + (UID_WIDTH+1)'(1);
      end else if (free_ok && !commit) begin
        outstanding <= outstanding - (UID_WIDTH+1)'(1);
      end
      if (free_bad) err_free_idle <= 1'b1;
    end
  end

  assign lookup_orig_id = map_table[lookup_uid];
  assign pool_full      = (outstanding == (UID_WIDTH+1)'(NUM_UIDS));

endmodule

// File: tb/tb_ar_uid_allocator.sv
// Scoreboard bench for ar_uid_allocator: expected UIDs queued at
// request time, compared when alloc_gnt appears.
module tb_ar_uid_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0;
  logic [3:0] alloc_in_id = '0;
  logic       alloc_commit = 1'b0;
  logic       alloc_gnt;
  logic [2:0] alloc_uid;
  logic       free_valid = 1'b0;
  logic [2:0] free_uid = '0;
  logic [2:0] lookup_uid = '0;
  logic [3:0] lookup_orig_id;
  logic [7:0] busy_vec;
  logic [3:0] outstanding;
  logic       pool_full;
  logic       err_free_idle;

  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] exp_q[$];

  ar_uid_allocator #(.ID_WIDTH(4), .UID_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_in_id(alloc_in_id),
    .alloc_commit(alloc_commit), .alloc_gnt(alloc_gnt),
    .alloc_uid(alloc_uid), .free_valid(free_valid),
    .free_uid(free_uid), .lookup_uid(lookup_uid),
    .lookup_orig_id(lookup_orig_id), .busy_vec(busy_vec),
    .outstanding(outstanding), .pool_full(pool_full),
    .err_free_idle(err_free_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    alloc_req = 1'b0;
    alloc_commit = 1'b0;
    free_valid = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    chk("rst_gnt", 32'(alloc_gnt), 0);
    chk("rst_busy", 32'(busy_vec), 0);
    chk("rst_out", 32'(outstanding), 0);
  endtask

  // Waits for a grant, then pops and compares the expected UID.
  task automatic wait_gnt(input string tag, output int lat);
    logic [2:0] e;
    lat = 0;
    while (!alloc_gnt && lat < 20) begin
      tick();
      lat++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'd0;
    if (!alloc_gnt) chk({tag, "_timeout"}, 0, 1);
    else chk({tag, "_uid"}, 32'(alloc_uid), 32'(e));
  endtask

  task automatic do_alloc(input logic [3:0] id,
                          input logic [2:0] uid);
    int lat;
    exp_q.push_back(uid);
    alloc_req = 1'b1;
    alloc_in_id = id;
    wait_gnt("alloc", lat);
    alloc_commit = 1'b1;
    tick();
    alloc_commit = 1'b0;
    alloc_req = 1'b0;
    lookup_uid = uid;
    #1;
    chk("alloc_map", 32'(lookup_orig_id), 32'(id));
  endtask

  initial begin
    int lat;
    int hi;

    do_reset();
    chk("rst_err", 32'(err_free_idle), 0);
    chk("rst_map", 32'(lookup_orig_id), 0);

    exp_q.push_back(3'd0);
    alloc_req = 1'b1;
    alloc_in_id = 4'h5;
    wait_gnt("first", lat);
    chk("first_lat", 32'(lat), 1);
    alloc_commit = 1'b1;
    tick();
    alloc_commit = 1'b0;
    alloc_req = 1'b0;
    lookup_uid = 3'd0;
    #1;
    chk("first_busy", 32'(busy_vec), 32'h01);
    chk("first_out", 32'(outstanding), 1);
    chk("first_map", 32'(lookup_orig_id), 5);
    chk("first_gap", 32'(alloc_gnt), 0);

    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(4'(i), 3'(i));
    chk("full_flag", 32'(pool_full), 1);
    chk("full_busy", 32'(busy_vec), 32'hFF);
    chk("full_out", 32'(outstanding), 8);

    exp_q.push_back(3'd3);
    alloc_req = 1'b1;
    alloc_in_id = 4'hA;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (alloc_gnt) hi++;
    end
    chk("full_stall", 32'(hi), 0);
    free_valid = 1'b1;
    free_uid = 3'd3;
    tick();
    free_valid = 1'b0;
    chk("free3_busy", 32'(busy_vec), 32'hF7);
    chk("free3_full", 32'(pool_full), 0);
    chk("free3_nogntyet", 32'(alloc_gnt), 0);
    tick();
    chk("regrant_gnt", 32'(alloc_gnt), 1);
    wait_gnt("regrant", lat);
    alloc_commit = 1'b1;
    tick();
    alloc_commit = 1'b0;
    alloc_req = 1'b0;
    lookup_uid = 3'd3;
    #1;
    chk("regrant_map", 32'(lookup_orig_id), 32'hA);
    chk("regrant_full", 32'(pool_full), 1);

    do_reset();
    do_alloc(4'h1, 3'd0);
    do_alloc(4'h2, 3'd1);
    chk("pair_busy", 32'(busy_vec), 32'h03);
    exp_q.push_back(3'd2);
    alloc_req = 1'b1;
    alloc_in_id = 4'h9;
    wait_gnt("simul", lat);
    alloc_commit = 1'b1;
    free_valid = 1'b1;
    free_uid = 3'd0;
    tick();
    alloc_commit = 1'b0;
    alloc_req = 1'b0;
    free_valid = 1'b0;
    lookup_uid = 3'd2;
    #1;
    chk("simul_busy", 32'(busy_vec), 32'h06);
    chk("simul_out", 32'(outstanding), 2);
    chk("simul_map", 32'(lookup_orig_id), 32'h9);

    free_valid = 1'b1;
    free_uid = 3'd6;
    tick();
    free_valid = 1'b0;
    chk("bad_err", 32'(err_free_idle), 1);
    chk("bad_out", 32'(outstanding), 2);
    chk("bad_busy", 32'(busy_vec), 32'h06);
    repeat (3) tick();
    chk("bad_sticky", 32'(err_free_idle), 1);

    exp_q.push_back(3'd0);
    alloc_req = 1'b1;
    alloc_in_id = 4'h7;
    wait_gnt("abort", lat);
    alloc_req = 1'b0;
    tick();
    chk("abort_gnt", 32'(alloc_gnt), 0);
    chk("abort_busy", 32'(busy_vec), 32'h06);
    chk("abort_out", 32'(outstanding), 2);

    do_alloc(4'hC, 3'd0);
    chk("three_out", 32'(outstanding), 3);
    exp_q.push_back(3'd3);
    alloc_req = 1'b1;
    alloc_in_id = 4'hD;
    wait_gnt("midrst", lat);
    #2;
    rst = 1'b0;
    #1;
    chk("async_gnt", 32'(alloc_gnt), 0);
    chk("async_busy", 32'(busy_vec), 0);
    chk("async_out", 32'(outstanding), 0);
    chk("async_err", 32'(err_free_idle), 0);
    alloc_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_alloc(4'hE, 3'd0);
    chk("post_busy", 32'(busy_vec), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
